// File: rtl/jt12_timer_pkg.sv
// Shared widths, limits and default prescaler ratios for the OPN Timer A/B block.
package jt12_timer_pkg;

  localparam int TA_W = 10;
  localparam int TB_W = 8;

  localparam logic [TA_W-1:0] TA_MAX = 10'h3FF;
  localparam logic [TB_W-1:0] TB_MAX = 8'hFF;

  localparam int DEF_A_PRES = 24;
  localparam int DEF_B_PRES = 16;

  // Prescaler widths cover the full legal ratio ranges (A: 1..63, B: 1..31).
  localparam int PRE_A_W = 6;
  localparam int PRE_B_W = 5;

endpackage

// File: rtl/jt12_opn_timers_if.sv
// Register-side bundle of the timer block: reload values, control bits, flags and IRQ.
interface jt12_opn_timers_if;
  import jt12_timer_pkg::*;

  logic            clk_en;
  logic [TA_W-1:0] value_A;
  logic [TB_W-1:0] value_B;
  logic            load_A;
  logic            load_B;
  logic            en_irq_A;
  logic            en_irq_B;
  logic            clr_flag_A;
  logic            clr_flag_B;
  logic            flag_A;
  logic            flag_B;
  logic            overflow_A;
  logic            irq_n;

  modport master (
    output clk_en, value_A, value_B, load_A, load_B,
           en_irq_A, en_irq_B, clr_flag_A, clr_flag_B,
    input  flag_A, flag_B, overflow_A, irq_n
  );

  modport slave (
    input  clk_en, value_A, value_B, load_A, load_B,
           en_irq_A, en_irq_B, clr_flag_A, clr_flag_B,
    output flag_A, flag_B, overflow_A, irq_n
  );

endinterface

// File: rtl/jt12_opn_timer_ch.sv
// One OPN timer channel: load-edge detect, up-counter with reload, overflow pulse, flag.
module jt12_opn_timer_ch
  import jt12_timer_pkg::*;
#(
  parameter int             W   = TA_W,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en_irq,
  input  logic         i_clr,
  output logic         o_flag,
  output logic         o_overflow
);

  logic         r_load_d;
  logic [W-1:0] r_cnt;
  logic         r_overflow;
  logic         r_flag;

  logic         w_load_edge;
  logic         w_ovf;

  assign w_load_edge = i_load & ~r_load_d;
  // A load edge swallows a coincident tick, so it can never overflow in that cycle.
  assign w_ovf       = i_load & i_tick & ~w_load_edge & (r_cnt == MAX);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values and the block order inside always_ff does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_d   <= 1'b0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_flag     <= 1'b0;
    end else begin
      r_load_d   <= i_load;
      r_overflow <= w_ovf;

      if (w_load_edge || w_ovf) begin
        r_cnt <= i_value;
      end else if (i_load && i_tick) begin
        r_cnt <= r_cnt + W'(1);
      end

      // Set has priority over clear so an overflow event is never lost.
      if (w_ovf && i_en_irq) begin
        r_flag <= 1'b1;
      end else if (i_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_flag     = r_flag;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/jt12_opn_timers.sv
// OPN Timer A/B: FM-sample and Timer B prescalers, two timer channels, registered IRQ.
module jt12_opn_timers
  import jt12_timer_pkg::*;
#(
  parameter int A_PRES = DEF_A_PRES,
  parameter int B_PRES = DEF_B_PRES
) (
  input  logic           clk,
  input  logic           rst,
  jt12_opn_timers_if.slave bus
);

  logic [PRE_A_W-1:0] r_pre_a;
  logic [PRE_B_W-1:0] r_pre_b;
  logic               r_irq_n;

  logic w_tick_a;
  logic w_tick_b;
  logic w_flag_a;
  logic w_flag_b;
  logic w_ovf_a;
  logic w_ovf_b_unused;

  assign w_tick_a = bus.clk_en && (r_pre_a == PRE_A_W'(A_PRES - 1));
  assign w_tick_b = w_tick_a   && (r_pre_b == PRE_B_W'(B_PRES - 1));

  // Prescalers are free-running; timer load bits never restart them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_a <= '0;
      r_pre_b <= '0;
      r_irq_n <= 1'b1;
    end else begin
      if (bus.clk_en) begin
        r_pre_a <= w_tick_a ? '0 : r_pre_a + PRE_A_W'(1);
      end
      if (w_tick_a) begin
        r_pre_b <= w_tick_b ? '0 : r_pre_b + PRE_B_W'(1);
      end
      r_irq_n <= ~(w_flag_a | w_flag_b);
    end
  end

  jt12_opn_timer_ch #(.W(TA_W), .MAX(TA_MAX)) u_ch_a (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (w_tick_a),
    .i_load     (bus.load_A),
    .i_value    (bus.value_A),
    .i_en_irq   (bus.en_irq_A),
    .i_clr      (bus.clr_flag_A),
    .o_flag     (w_flag_a),
    .o_overflow (w_ovf_a)
  );

  // Timer B has no overflow pulse output; its channel pulse is left dangling.
  jt12_opn_timer_ch #(.W(TB_W), .MAX(TB_MAX)) u_ch_b (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (w_tick_b),
    .i_load     (bus.load_B),
    .i_value    (bus.value_B),
    .i_en_irq   (bus.en_irq_B),
    .i_clr      (bus.clr_flag_B),
    .o_flag     (w_flag_b),
    .o_overflow (w_ovf_b_unused)
  );

  assign bus.flag_A     = w_flag_a;
  assign bus.flag_B     = w_flag_b;
  assign bus.overflow_A = w_ovf_a;
  assign bus.irq_n      = r_irq_n;

endmodule

// File: tb/tb_jt12_opn_timers.sv
// Directed bench for jt12_opn_timers: expected overflow_A edges are queued by the stimulus
// and popped by an independent monitor; flags and irq_n are checked at hand-derived edges.
module tb_jt12_opn_timers;
  import jt12_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jt12_opn_timers_if bus ();

  jt12_opn_timers #(.A_PRES(24), .B_PRES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int e;            // posedges since reset release
  int en_mode;      // 0: clk_en low, 1: every edge, 2: odd edges only
  int exp_q[$];     // edges at which overflow_A is required

  always @(posedge clk or posedge rst) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  // clk_en for the next edge (index e+1) is set up on the preceding negedge.
  always @(negedge clk) begin
    case (en_mode)
      1:       bus.clk_en = 1'b1;
      2:       bus.clk_en = (e % 2 == 0);
      default: bus.clk_en = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d, t=%0t)", name, act, req, e, $time);
    end
  endtask

  // Monitor: every overflow_A pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && bus.overflow_A === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ovf_A_unexpected: pulse seen after edge %0d, none required", e);
      end else begin
        check("ovf_A_edge", e, exp_q.pop_front());
      end
    end
  end

  task automatic go_to(input int n);
    while (e < n) @(negedge clk);
  endtask

  task automatic do_reset(input int mode);
    check("pending_ovf_A", exp_q.size(), 0);
    rst            = 1'b1;
    en_mode        = mode;
    bus.value_A    = '0;
    bus.value_B    = '0;
    bus.load_A     = 1'b0;
    bus.load_B     = 1'b0;
    bus.en_irq_A   = 1'b0;
    bus.en_irq_B   = 1'b0;
    bus.clr_flag_A = 1'b0;
    bus.clr_flag_B = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_flag_A", int'(bus.flag_A), 0);
    check("rst_flag_B", int'(bus.flag_B), 0);
    check("rst_ovf_A",  int'(bus.overflow_A), 0);
    check("rst_irq_n",  int'(bus.irq_n), 1);
    rst = 1'b0;
  endtask

  initial begin
    en_mode = 0;

    // Idle: nothing loaded, clk_en every cycle.
    do_reset(1);
    go_to(500);
    check("idle_flag_A", int'(bus.flag_A), 0);
    check("idle_flag_B", int'(bus.flag_B), 0);
    check("idle_irq_n",  int'(bus.irq_n), 1);

    // Timer A at 1020: load at edge 10, ticks every 24 edges, 4th tick overflows.
    do_reset(1);
    bus.value_A  = 10'd1020;
    bus.en_irq_A = 1'b1;
    go_to(9);
    bus.load_A = 1'b1;
    exp_q.push_back(96);
    exp_q.push_back(192);
    go_to(95);  check("a_flag_before", int'(bus.flag_A), 0);
    go_to(96);  check("a_flag_set", int'(bus.flag_A), 1);
                check("a_irq_lag", int'(bus.irq_n), 1);
    go_to(97);  check("a_irq_low", int'(bus.irq_n), 0);
    go_to(99);  bus.value_A = 10'd1022;      // takes effect at the reload on edge 192
    exp_q.push_back(240);
    exp_q.push_back(288);
    go_to(191); bus.clr_flag_A = 1'b1;        // clear coincides with set at edge 192
    go_to(192); bus.clr_flag_A = 1'b0;
                check("a_set_beats_clr", int'(bus.flag_A), 1);
    go_to(199); bus.clr_flag_A = 1'b1;
    go_to(200); bus.clr_flag_A = 1'b0;
                check("a_clr", int'(bus.flag_A), 0);
                check("a_clr_irq_lag", int'(bus.irq_n), 0);
    go_to(201); check("a_clr_irq_high", int'(bus.irq_n), 1);
    go_to(239); check("a_flag_pre240", int'(bus.flag_A), 0);
    go_to(240); check("a_flag_240", int'(bus.flag_A), 1);
    go_to(299); bus.load_A = 1'b0;
    go_to(400); check("a_stop_keeps_flag", int'(bus.flag_A), 1);

    // Timer B at 255: first tick_B (edge 384) overflows, then every 384.
    do_reset(1);
    bus.value_B  = 8'd255;
    bus.en_irq_B = 1'b1;
    go_to(9);   bus.load_B = 1'b1;
    go_to(383); check("b_flag_before", int'(bus.flag_B), 0);
    go_to(384); check("b_flag_set", int'(bus.flag_B), 1);
                check("b_irq_lag", int'(bus.irq_n), 1);
    go_to(385); check("b_irq_low", int'(bus.irq_n), 0);
    go_to(399); bus.clr_flag_B = 1'b1;
    go_to(400); bus.clr_flag_B = 1'b0;
                check("b_clr", int'(bus.flag_B), 0);
    go_to(401); check("b_clr_irq_high", int'(bus.irq_n), 1);
    go_to(767); check("b_flag_pre768", int'(bus.flag_B), 0);
    go_to(768); check("b_flag_768", int'(bus.flag_B), 1);
                check("b_no_flag_A", int'(bus.flag_A), 0);

    // Timer A at 1023 with flag disabled; load edge lands on tick edge 24 and wins.
    do_reset(1);
    bus.value_A = 10'd1023;
    go_to(23);  bus.load_A = 1'b1;
    for (int k = 2; k <= 6; k++) exp_q.push_back(24 * k);
    go_to(145); check("a_masked_flag", int'(bus.flag_A), 0);
                check("a_masked_irq", int'(bus.irq_n), 1);
    go_to(149); bus.load_A = 1'b0;
    go_to(300); check("a_frozen_flag", int'(bus.flag_A), 0);

    // clk_en on odd edges only: tick_A every 48 edges (47, 95, ...), then async reset.
    do_reset(2);
    bus.value_A  = 10'd1023;
    bus.en_irq_A = 1'b1;
    go_to(9);   bus.load_A = 1'b1;
    exp_q.push_back(47);
    exp_q.push_back(95);
    go_to(46);  check("h_flag_before", int'(bus.flag_A), 0);
    go_to(47);  check("h_flag_set", int'(bus.flag_A), 1);
    go_to(97);  check("h_irq_low", int'(bus.irq_n), 0);
    #2 rst = 1'b1;
    #1;
    check("async_flag_A", int'(bus.flag_A), 0);
    check("async_ovf_A",  int'(bus.overflow_A), 0);
    check("async_irq_n",  int'(bus.irq_n), 1);
    do_reset(0);
    repeat (4) @(negedge clk);
    check("pending_ovf_A_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
